// File: rtl/voq_pkg.sv
// Shared types and width helpers for the VOQ manager.
// Widths derive from VOQ_CNT/DEPTH through the functions below so modules can size themselves from their own parameters.
`timescale 1ns/1ps
package voq_pkg;

    localparam int VOQ_CNT_DEF    = 4;
    localparam int DEPTH_DEF      = 1024;
    localparam int DATA_WIDTH_DEF = 32;

    function automatic int idx_w(input int voq_cnt);
        return (voq_cnt < 2) ? 1 : $clog2(voq_cnt);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // One extra bit so a full queue (count == DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    localparam int VOQ_IDX_W = idx_w(VOQ_CNT_DEF);
    localparam int PTR_W     = ptr_w(DEPTH_DEF);
    localparam int CNT_W     = cnt_w(DEPTH_DEF);

    typedef logic [VOQ_IDX_W-1:0]      voq_idx_t;
    typedef logic [DATA_WIDTH_DEF-1:0] voq_entry_t;

endpackage

// File: rtl/simple_dual_port_mem.sv
// One write port, one registered read port; a read and a write to the same
// address in one cycle return the old word.
`timescale 1ns/1ps
module simple_dual_port_mem #(
    parameter int MEM_SIZE   = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/voq_mgr.sv
// Virtual-output-queue manager: VOQ_CNT ring FIFOs sharing one dual-port memory.
// Define VOQ_MGR_DROP_STATS_EN to add per-VOQ saturating drop counters and their read/clear ports.
`timescale 1ns/1ps
module voq_mgr
    import voq_pkg::*;
#(
    parameter int VOQ_CNT    = 4,
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       enq_en,
    input  logic [$clog2(VOQ_CNT)-1:0]                 enq_sel,
    input  logic [DATA_WIDTH-1:0]                      enq_data,
    output logic                                       enq_drop,
    input  logic                                       deq_en,
    input  logic [$clog2(VOQ_CNT)-1:0]                 deq_sel,
    output logic                                       deq_valid,
    output logic [DATA_WIDTH-1:0]                      deq_data,
    output logic [VOQ_CNT-1:0]                         is_empty,
    output logic [VOQ_CNT-1:0]                         is_full,
    output logic [VOQ_CNT*($clog2(DEPTH)+1)-1:0]       occupancy
`ifdef VOQ_MGR_DROP_STATS_EN
    ,
    input  logic [$clog2(VOQ_CNT)-1:0]                 stat_sel,
    input  logic                                       stat_clr,
    output logic [15:0]                                drop_cnt
`endif
);

    localparam int IW = idx_w(VOQ_CNT);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int AW = IW + PW;

    logic [VOQ_CNT-1:0][PW-1:0] head, tail;
    logic [VOQ_CNT-1:0][CW-1:0] cnt;

    logic enq_acc, deq_acc, enq_rej;
    logic deq_vld_q;
    logic [DATA_WIDTH-1:0] rdata;

    // Flags come from registered counts only, so acceptance never loops back on itself.
    assign enq_acc = !reset && enq_en && !is_full[enq_sel];
    assign deq_acc = !reset && deq_en && !is_empty[deq_sel];
    assign enq_rej = !reset && enq_en &&  is_full[enq_sel];

    simple_dual_port_mem #(
        .MEM_SIZE  (VOQ_CNT*DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_W    (AW)
    ) u_mem (
        .clk  (clk),
        .we   (enq_acc),
        .waddr({enq_sel, tail[enq_sel]}),
        .wdata(enq_data),
        .re   (deq_acc),
        .raddr({deq_sel, head[deq_sel]}),
        .rdata(rdata)
    );

    for (genvar i = 0; i < VOQ_CNT; i++) begin : g_q
        logic e, d;
        assign e = enq_acc && (enq_sel == IW'(i));
        assign d = deq_acc && (deq_sel == IW'(i));

        always_ff @(posedge clk) begin
            if (reset) begin
                head[i] <= '0;
                tail[i] <= '0;
                cnt[i]  <= '0;
            end else begin
                if (e) tail[i] <= tail[i] + PW'(1);
                if (d) head[i] <= head[i] + PW'(1);
                cnt[i] <= cnt[i] + CW'(e) - CW'(d);
            end
        end

        assign is_empty[i] = (cnt[i] == '0);
        assign is_full[i]  = (cnt[i] == CW'(DEPTH));
        assign occupancy[i*CW +: CW] = cnt[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deq_vld_q <= 1'b0;
            enq_drop  <= 1'b0;
        end else begin
            deq_vld_q <= deq_acc;
            enq_drop  <= enq_rej;
        end
    end

    assign deq_valid = deq_vld_q;
    assign deq_data  = deq_vld_q ? rdata : '0;

`ifdef VOQ_MGR_DROP_STATS_EN
    logic [VOQ_CNT-1:0][15:0] drop_ctr;

    for (genvar i = 0; i < VOQ_CNT; i++) begin : g_stat
        // A clear on the selected queue beats a same-cycle drop.
        always_ff @(posedge clk) begin
            if (reset)
                drop_ctr[i] <= '0;
            else if (stat_clr && stat_sel == IW'(i))
                drop_ctr[i] <= '0;
            else if (enq_rej && enq_sel == IW'(i) && drop_ctr[i] != 16'hFFFF)
                drop_ctr[i] <= drop_ctr[i] + 16'd1;
        end
    end

    assign drop_cnt = drop_ctr[stat_sel];
`endif

endmodule

// File: tb/tb_voq_mgr.sv
// Randomised and directed bench for voq_mgr (DEPTH=8) against a queue-based reference model.
`timescale 1ns/1ps
module tb_voq_mgr;

    localparam int VOQ_CNT = 4;
    localparam int DEPTH   = 8;
    localparam int DW      = 32;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    logic enq_en, deq_en;
    logic [1:0] enq_sel, deq_sel;
    logic [DW-1:0] enq_data;
    logic enq_drop, deq_valid;
    logic [DW-1:0] deq_data;
    logic [VOQ_CNT-1:0] is_empty, is_full;
    logic [VOQ_CNT*CW-1:0] occupancy;
`ifdef VOQ_MGR_DROP_STATS_EN
    logic [1:0] stat_sel;
    logic stat_clr;
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    voq_mgr #(.VOQ_CNT(VOQ_CNT), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .enq_en(enq_en), .enq_sel(enq_sel), .enq_data(enq_data), .enq_drop(enq_drop),
        .deq_en(deq_en), .deq_sel(deq_sel), .deq_valid(deq_valid), .deq_data(deq_data),
        .is_empty(is_empty), .is_full(is_full), .occupancy(occupancy)
`ifdef VOQ_MGR_DROP_STATS_EN
        , .stat_sel(stat_sel), .stat_clr(stat_clr), .drop_cnt(drop_cnt)
`endif
    );

    // Reference model: one queue per VOQ plus saturating drop totals.
    logic [DW-1:0] mq [VOQ_CNT][$];
    int dc [VOQ_CNT];
    int n_chk = 0;
    int n_fail = 0;
    logic exp_valid, exp_drop;
    logic [DW-1:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("deq_valid", 64'(deq_valid), 64'(exp_valid));
        chk("deq_data", 64'(deq_data), 64'(exp_data));
        chk("enq_drop", 64'(enq_drop), 64'(exp_drop));
        for (int i = 0; i < VOQ_CNT; i++) begin
            chk($sformatf("occupancy[%0d]", i), 64'(occupancy[i*CW +: CW]), 64'(mq[i].size()));
            chk($sformatf("is_empty[%0d]", i), 64'(is_empty[i]), 64'(mq[i].size() == 0));
            chk($sformatf("is_full[%0d]", i), 64'(is_full[i]), 64'(mq[i].size() == DEPTH));
        end
`ifdef VOQ_MGR_DROP_STATS_EN
        chk("drop_cnt", 64'(drop_cnt), 64'(dc[stat_sel]));
`endif
    endtask

    task automatic step(input logic ee, input int es, input logic [DW-1:0] ed,
                        input logic de, input int ds);
        bit acc_e, acc_d, rej;
        acc_e = ee && (mq[es].size() < DEPTH);
        rej   = ee && !acc_e;
        acc_d = de && (mq[ds].size() > 0);
        exp_valid = acc_d;
        exp_data  = acc_d ? mq[ds][0] : '0;
        exp_drop  = rej;
        if (acc_d) void'(mq[ds].pop_front());
        if (acc_e) mq[es].push_back(ed);
        if (rej && dc[es] < 16'hFFFF) dc[es]++;
`ifdef VOQ_MGR_DROP_STATS_EN
        if (stat_clr) dc[stat_sel] = 0;
`endif
        enq_en = ee; enq_sel = 2'(es); enq_data = ed;
        deq_en = de; deq_sel = 2'(ds);
        @(posedge clk); #1;
        enq_en = 1'b0; deq_en = 1'b0;
        check_all();
    endtask

    // Requests present during reset must be ignored.
    task automatic do_reset();
        reset = 1'b1;
        enq_en = 1'b1; enq_sel = 2'd1; enq_data = 32'hDEAD;
        deq_en = 1'b1; deq_sel = 2'd2;
        @(posedge clk); #1;
        reset = 1'b0; enq_en = 1'b0; deq_en = 1'b0;
        for (int i = 0; i < VOQ_CNT; i++) begin
            mq[i].delete();
            dc[i] = 0;
        end
        exp_valid = 1'b0; exp_data = '0; exp_drop = 1'b0;
        check_all();
    endtask

    initial begin
        reset = 1'b1; enq_en = 1'b0; deq_en = 1'b0;
        enq_sel = '0; deq_sel = '0; enq_data = '0;
`ifdef VOQ_MGR_DROP_STATS_EN
        stat_sel = 2'd0; stat_clr = 1'b0;
`endif
        @(posedge clk); #1;
        do_reset();

        // In-order delivery on VOQ2.
        for (int k = 0; k < 4; k++) step(1, 2, 32'hA0 + 32'(k), 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 2);

        // Fill VOQ1 past capacity, then drain across the pointer wrap.
        for (int k = 1; k <= 9; k++) step(1, 1, 32'(k), 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 1);

        // Empty VOQ0: enqueue wins, dequeue rejected.
        step(1, 0, 32'h55, 1, 0);
        step(0, 0, 0, 1, 0);

        // Full VOQ3: dequeue returns oldest, enqueue dropped.
        for (int k = 0; k < 8; k++) step(1, 3, 32'h300 + 32'(k), 0, 0);
        step(1, 3, 32'h3FF, 1, 3);
        step(1, 3, 32'h3FE, 1, 3);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 3);

        // Concurrent enqueue VOQ1 / dequeue VOQ2.
        for (int k = 0; k < 4; k++) step(1, 2, $urandom, 0, 0);
        for (int k = 0; k < 20; k++)
            step(1'($urandom_range(0, 1)), 1, $urandom, 1'($urandom_range(0, 1)), 2);

        // Unconstrained random traffic.
        for (int k = 0; k < 300; k++)
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)));

        // Reset with a dequeue result in flight.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 32'hC0 + 32'(k), 0, 0);
        step(0, 0, 0, 1, 0);
        do_reset();

`ifdef VOQ_MGR_DROP_STATS_EN
        stat_sel = 2'd0;
        for (int k = 0; k < 8; k++) step(1, 0, 32'(k), 0, 0);
        for (int k = 0; k < 65540; k++) step(1, 0, 32'hEE, 0, 0);
        chk("drop_cnt_sat", 64'(drop_cnt), 64'hFFFF);
        stat_clr = 1'b1;
        step(1, 0, 32'hEE, 0, 0);
        stat_clr = 1'b0;
        chk("drop_cnt_clr", 64'(drop_cnt), 64'h0);
        step(1, 0, 32'hEE, 0, 0);
        do_reset();
        chk("drop_cnt_rst", 64'(drop_cnt), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
